ddr2_init_seq: RTL

DDR2_INIT_SEQ -- requirements
Module: ddr2_init_seq

---
 rtl/ddr2_init_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ddr2_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_init_seq
// Brief    : DDR2 SDRAM power-up initialisation sequencer. Walks the JEDEC
//            init steps (CKE wait, PRE-ALL, EMRS2/3/1, MRS with DLL reset,
//            PRE-ALL, 2x REF, MRS, OCD default/exit) and then holds in DONE.
// Revision : 1.0 - initial release
// ============================================================================
module ddr2_init_seq #(
  parameter int          T_INIT = 25000,
  parameter int          T_CKE  = 50,
  parameter int          T_RP   = 3,
  parameter int          T_MRD  = 2,
  parameter int          T_RFC  = 16,
  parameter logic [12:0] MR     = 13'h0432,
  parameter logic [12:0] EMR1   = 13'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  output logic        cke,
  output logic [2:0]  cmd,
  output logic [1:0]  ba,
  output logic [12:0] a,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;

  // Wait counter reload values (Tx-1 so the step occupies exactly Tx cycles)
  localparam logic [15:0] L_INIT = 16'(T_INIT - 1);
  localparam logic [15:0] L_CKE  = 16'(T_CKE - 1);
  localparam logic [15:0] L_RP   = 16'(T_RP - 1);
  localparam logic [15:0] L_MRD  = 16'(T_MRD - 1);
  localparam logic [15:0] L_RFC  = 16'(T_RFC - 1);

  typedef enum logic [3:0] {
    S0_WAIT_INIT = 4'd0,
    S1_CKE_ON    = 4'd1,
    S2_PRE       = 4'd2,
    S3_EMRS2     = 4'd3,
    S4_EMRS3     = 4'd4,
    S5_EMRS1     = 4'd5,
    S6_MRS_DLL   = 4'd6,
    S7_PRE       = 4'd7,
    S8_REF       = 4'd8,
    S9_REF       = 4'd9,
    S10_MRS      = 4'd10,
    S11_OCD_DEF  = 4'd11,
    S12_OCD_EXIT = 4'd12,
    S_DONE       = 4'd13
  } state_t;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        cke_nx, busy_nx, done_nx;
  logic [2:0]  cmd_nx;
  logic [1:0]  ba_nx;
  logic [12:0] a_nx;

  // Residency of each step, expressed as the counter reload value
  function automatic logic [15:0] load_of(input state_t s);
    case (s)
      S0_WAIT_INIT:        load_of = L_INIT;
      S1_CKE_ON:           load_of = L_CKE;
      S2_PRE, S7_PRE:      load_of = L_RP;
      S8_REF, S9_REF:      load_of = L_RFC;
      S_DONE:              load_of = 16'd0;
      default:             load_of = L_MRD;
    endcase
  endfunction

  // Next-state, counter and next-output logic; a command goes out only on step entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cmd_nx   = CMD_NOP;
    ba_nx    = 2'd0;
    a_nx     = 13'd0;
    if (state == S_DONE) begin
      if (init_req) begin
        state_nx = S0_WAIT_INIT;
        cnt_nx   = L_INIT;
      end
    end else if (cnt == 16'd0) begin
      state_nx = state_t'(4'(state) + 4'd1);
      cnt_nx   = load_of(state_nx);
      case (state_nx)
        S2_PRE, S7_PRE: begin cmd_nx = CMD_PRE; a_nx = 13'h0400; end
        S3_EMRS2:       begin cmd_nx = CMD_MRS; ba_nx = 2'd2; end
        S4_EMRS3:       begin cmd_nx = CMD_MRS; ba_nx = 2'd3; end
        S5_EMRS1:       begin cmd_nx = CMD_MRS; ba_nx = 2'd1; a_nx = EMR1; end
        S6_MRS_DLL:     begin cmd_nx = CMD_MRS; a_nx = MR | 13'h0100; end
        S8_REF, S9_REF: begin cmd_nx = CMD_REF; end
        S10_MRS:        begin cmd_nx = CMD_MRS; a_nx = MR; end
        S11_OCD_DEF:    begin cmd_nx = CMD_MRS; ba_nx = 2'd1; a_nx = EMR1 | 13'h0380; end
        S12_OCD_EXIT:   begin cmd_nx = CMD_MRS; ba_nx = 2'd1; a_nx = EMR1; end
        default:        ;
      endcase
    end else begin
      cnt_nx = cnt - 16'd1;
    end
    cke_nx  = (state_nx != S0_WAIT_INIT);
    busy_nx = (state_nx != S_DONE);
    done_nx = (state_nx == S_DONE);
  end

  // State, counter and registered outputs; reset aborts any step immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0_WAIT_INIT;
      cnt   <= L_INIT;
      cke   <= 1'b0;
      cmd   <= CMD_NOP;
      ba    <= 2'd0;
      a     <= 13'd0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cke   <= cke_nx;
      cmd   <= cmd_nx;
      ba    <= ba_nx;
      a     <= a_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

endmodule
`default_nettype wire
